// File: rtl/fp_add_exp_pack.sv
// Exponent-adjust and pack stage of the 8-bit FP adder: two-stage valid/ready
// pipeline that applies zero/overflow/underflow rules and counts saturation events.
module fp_add_exp_pack #(
  parameter int EXP_W  = 3,
  parameter int MANT_W = 4,
  parameter int CNT_W  = 8
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      in_valid,
  output logic                      in_ready,
  input  logic                      zero,
  input  logic                      sign_res,
  input  logic [MANT_W-1:0]         mant_res,
  input  logic [2:0]                exp_diff_norm,
  input  logic [1:0]                exp_diff_sign,
  input  logic [EXP_W-1:0]          exp_big,
  output logic                      out_valid,
  input  logic                      out_ready,
  output logic [EXP_W+MANT_W:0]     out_res,
  output logic                      out_ovf,
  output logic                      out_unf,
  input  logic                      clr_cnt,
  output logic [CNT_W-1:0]          ovf_cnt,
  output logic [CNT_W-1:0]          unf_cnt
);

  localparam int E_W   = EXP_W + 2;
  localparam int RES_W = 1 + EXP_W + MANT_W;
  localparam logic signed [E_W-1:0] EXP_MAX = E_W'((1 << EXP_W) - 1);

  typedef enum logic [1:0] {
    SHIFT_NONE = 2'b00,
    SHIFT_INC  = 2'b01,
    SHIFT_DEC  = 2'b10,
    SHIFT_RSVD = 2'b11
  } shift_dir_e;

  // Stage 1 state
  logic                    s1_valid_q, s1_valid_d;
  logic                    s1_zero_q,  s1_zero_d;
  logic                    s1_sign_q,  s1_sign_d;
  logic [MANT_W-1:0]       s1_mant_q,  s1_mant_d;
  logic signed [E_W-1:0]   s1_exp_q,   s1_exp_d;

  // Stage 2 state
  logic                    s2_valid_q, s2_valid_d;
  logic [RES_W-1:0]        res_q,      res_d;
  logic                    ovf_q,      ovf_d;
  logic                    unf_q,      unf_d;

  // Event counters
  logic [CNT_W-1:0]        ovf_cnt_q,  ovf_cnt_d;
  logic [CNT_W-1:0]        unf_cnt_q,  unf_cnt_d;

  logic                    s2_load;
  logic                    s1_accept;
  logic                    out_xfer;
  logic signed [E_W-1:0]   exp_base;
  logic signed [E_W-1:0]   exp_norm;
  logic signed [E_W-1:0]   exp_adj;
  logic [RES_W-1:0]        pack_res;
  logic                    pack_ovf;
  logic                    pack_unf;

  // Only out_ready reaches in_ready combinationally; in_valid only feeds flops.
  assign s2_load   = !s2_valid_q || out_ready;
  assign in_ready  = !s1_valid_q || s2_load;
  assign s1_accept = in_valid && in_ready;
  assign out_xfer  = s2_valid_q && out_ready;

  // Operands are widened by two bits so 7+7 and 0-7 stay representable.
  always_comb begin
    exp_base = signed'({2'b00, exp_big});
    exp_norm = signed'({{(E_W-3){1'b0}}, exp_diff_norm});
    case (shift_dir_e'(exp_diff_sign))
      SHIFT_INC: exp_adj = exp_base + exp_norm;
      SHIFT_DEC: exp_adj = exp_base - exp_norm;
      default:   exp_adj = exp_base;
    endcase
  end

  // NOTE: every always_comb output gets a default first so no path leaves it unassigned (no latch).
  always_comb begin
    pack_res = {s1_sign_q, s1_exp_q[EXP_W-1:0], s1_mant_q};
    pack_ovf = 1'b0;
    pack_unf = 1'b0;
    if (s1_zero_q) begin
      pack_res = '0;
    end else if (s1_exp_q > EXP_MAX) begin
      pack_res = {s1_sign_q, {EXP_W{1'b1}}, {MANT_W{1'b1}}};
      pack_ovf = 1'b1;
    end else if (s1_exp_q < 0) begin
      pack_res = '0;
      pack_unf = 1'b1;
    end
  end

  always_comb begin
    s1_valid_d = s1_valid_q;
    s1_zero_d  = s1_zero_q;
    s1_sign_d  = s1_sign_q;
    s1_mant_d  = s1_mant_q;
    s1_exp_d   = s1_exp_q;
    if (s1_accept) begin
      s1_valid_d = 1'b1;
      s1_zero_d  = zero;
      s1_sign_d  = sign_res;
      s1_mant_d  = mant_res;
      s1_exp_d   = exp_adj;
    end else if (s2_load) begin
      s1_valid_d = 1'b0;
    end
  end

  // Result payload only changes when real data moves in, so a stalled output is held.
  always_comb begin
    s2_valid_d = s2_valid_q;
    res_d      = res_q;
    ovf_d      = ovf_q;
    unf_d      = unf_q;
    if (s2_load) begin
      s2_valid_d = s1_valid_q;
      if (s1_valid_q) begin
        res_d = pack_res;
        ovf_d = pack_ovf;
        unf_d = pack_unf;
      end
    end
  end

  // Clear beats a same-cycle increment; increments stop at all-ones.
  always_comb begin
    ovf_cnt_d = ovf_cnt_q;
    unf_cnt_d = unf_cnt_q;
    if (clr_cnt) begin
      ovf_cnt_d = '0;
      unf_cnt_d = '0;
    end else if (out_xfer) begin
      if (ovf_q && (ovf_cnt_q != '1)) ovf_cnt_d = ovf_cnt_q + 1'b1;
      if (unf_q && (unf_cnt_q != '1)) unf_cnt_d = unf_cnt_q + 1'b1;
    end
  end

  // NOTE: sequential state uses non-blocking assignments so all flops update together at the edge.
  always_ff @(posedge clk) begin
    if (rst) begin
      s1_valid_q <= 1'b0;
      s2_valid_q <= 1'b0;
      res_q      <= '0;
      ovf_q      <= 1'b0;
      unf_q      <= 1'b0;
      ovf_cnt_q  <= '0;
      unf_cnt_q  <= '0;
    end else begin
      s1_valid_q <= s1_valid_d;
      s2_valid_q <= s2_valid_d;
      res_q      <= res_d;
      ovf_q      <= ovf_d;
      unf_q      <= unf_d;
      ovf_cnt_q  <= ovf_cnt_d;
      unf_cnt_q  <= unf_cnt_d;
    end
  end

  // NOTE: stage-1 payload is left unreset; it is qualified by s1_valid_q and never observed otherwise.
  always_ff @(posedge clk) begin
    s1_zero_q <= s1_zero_d;
    s1_sign_q <= s1_sign_d;
    s1_mant_q <= s1_mant_d;
    s1_exp_q  <= s1_exp_d;
  end

  assign out_valid = s2_valid_q;
  assign out_res   = res_q;
  assign out_ovf   = ovf_q;
  assign out_unf   = unf_q;
  assign ovf_cnt   = ovf_cnt_q;
  assign unf_cnt   = unf_cnt_q;

endmodule

// File: tb/tb_fp_add_exp_pack.sv
// Self-checking bench for fp_add_exp_pack: directed scenarios plus random traffic
// scored against an arithmetic reference model and an in-order result queue.
module tb_fp_add_exp_pack;

  logic       clk = 1'b0;
  logic       rst;
  logic       in_valid;
  logic       in_ready;
  logic       zero;
  logic       sign_res;
  logic [3:0] mant_res;
  logic [2:0] exp_diff_norm;
  logic [1:0] exp_diff_sign;
  logic [2:0] exp_big;
  logic       out_valid;
  logic       out_ready;
  logic [7:0] out_res;
  logic       out_ovf;
  logic       out_unf;
  logic       clr_cnt;
  logic [7:0] ovf_cnt;
  logic [7:0] unf_cnt;

  int checks   = 0;
  int failures = 0;
  int m_ovf    = 0;
  int m_unf    = 0;
  int n_xfer   = 0;
  bit last_acc = 1'b0;
  logic [9:0] sb[$];   // {ovf, unf, res}

  fp_add_exp_pack dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
    .zero(zero), .sign_res(sign_res), .mant_res(mant_res),
    .exp_diff_norm(exp_diff_norm), .exp_diff_sign(exp_diff_sign), .exp_big(exp_big),
    .out_valid(out_valid), .out_ready(out_ready), .out_res(out_res),
    .out_ovf(out_ovf), .out_unf(out_unf), .clr_cnt(clr_cnt),
    .ovf_cnt(ovf_cnt), .unf_cnt(unf_cnt)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  // Reference: exponent as a plain integer, then the zero/overflow/underflow rules.
  function automatic logic [9:0] ref_result(input logic z, input logic s, input logic [3:0] m,
                                            input logic [2:0] n, input logic [1:0] d,
                                            input logic [2:0] eb);
    int e;
    e = int'(eb);
    if (d == 2'b01) e = e + int'(n);
    else if (d == 2'b10) e = e - int'(n);
    if (z) return 10'h000;
    if (e > 7) return {2'b10, s, 7'h7F};
    if (e < 0) return {2'b01, 8'h00};
    return {2'b00, s, 3'(e), m};
  endfunction

  task automatic drive(input bit v, input bit z, input bit s, input logic [3:0] m,
                       input logic [2:0] n, input logic [1:0] d, input logic [2:0] eb);
    in_valid = v; zero = z; sign_res = s; mant_res = m;
    exp_diff_norm = n; exp_diff_sign = d; exp_big = eb;
  endtask

  // One clock: score handshakes seen before the edge, then check counters after it.
  task automatic cycle();
    bit acc, xfr;
    logic [9:0] exp;
    int nxt_ovf, nxt_unf;
    #1;
    acc = !rst && in_valid && in_ready;
    xfr = !rst && out_valid && out_ready;
    nxt_ovf = m_ovf;
    nxt_unf = m_unf;
    if (xfr) begin
      if (sb.size() == 0) begin
        check("spurious_out", {31'd0, out_valid}, 32'd0);
      end else begin
        exp = sb.pop_front();
        n_xfer++;
        check("out_res", {24'd0, out_res}, {24'd0, exp[7:0]});
        check("out_ovf", {31'd0, out_ovf}, {31'd0, exp[9]});
        check("out_unf", {31'd0, out_unf}, {31'd0, exp[8]});
        if (exp[9] && nxt_ovf < 255) nxt_ovf++;
        if (exp[8] && nxt_unf < 255) nxt_unf++;
      end
    end
    if (acc) sb.push_back(ref_result(zero, sign_res, mant_res, exp_diff_norm, exp_diff_sign, exp_big));
    if (rst || clr_cnt) begin
      nxt_ovf = 0;
      nxt_unf = 0;
    end
    if (rst) sb.delete();
    last_acc = acc;
    @(posedge clk);
    @(negedge clk);
    m_ovf = nxt_ovf;
    m_unf = nxt_unf;
    check("ovf_cnt", {24'd0, ovf_cnt}, 32'(m_ovf));
    check("unf_cnt", {24'd0, unf_cnt}, 32'(m_unf));
  endtask

  task automatic drain();
    in_valid = 1'b0;
    out_ready = 1'b1;
    for (int i = 0; i < 20 && sb.size() > 0; i++) cycle();
    check("drain_left", 32'(sb.size()), 32'd0);
  endtask

  initial begin
    logic [9:0] held;
    int sent;

    rst = 1'b1; clr_cnt = 1'b0; out_ready = 1'b0;
    drive(0, 0, 0, 4'h0, 3'd0, 2'b00, 3'd0);
    @(negedge clk);
    cycle();
    cycle();
    check("rst_out_valid", {31'd0, out_valid}, 32'd0);
    check("rst_out_res", {24'd0, out_res}, 32'd0);
    check("rst_flags", {30'd0, out_ovf, out_unf}, 32'd0);
    rst = 1'b0;
    cycle();
    check("rst_in_ready", {31'd0, in_ready}, 32'd1);

    // Normal add with explicit two-cycle latency
    out_ready = 1'b1;
    drive(1, 0, 0, 4'h5, 3'd1, 2'b01, 3'd3);
    cycle();
    in_valid = 1'b0;
    check("lat_not_yet", {31'd0, out_valid}, 32'd0);
    cycle();
    check("lat_valid", {31'd0, out_valid}, 32'd1);
    check("normal_res", {24'd0, out_res}, 32'h45);
    cycle();

    // Overflow, underflow, zero priority, reserved direction
    drive(1, 0, 1, 4'h3, 3'd1, 2'b01, 3'd7); cycle();
    drive(1, 0, 0, 4'h9, 3'd3, 2'b10, 3'd1); cycle();
    drive(1, 1, 1, 4'hA, 3'd1, 2'b01, 3'd7); cycle();
    drive(1, 0, 1, 4'h6, 3'd3, 2'b11, 3'd5); cycle();
    drive(1, 0, 0, 4'hF, 3'd7, 2'b01, 3'd7); cycle();
    drive(1, 0, 0, 4'h1, 3'd7, 2'b10, 3'd7); cycle();
    drain();
    check("ovf_cnt_dir", {24'd0, ovf_cnt}, 32'd2);
    check("unf_cnt_dir", {24'd0, unf_cnt}, 32'd1);

    // Backpressure: fill both stages, stall three cycles, release
    n_xfer = 0;
    out_ready = 1'b0;
    drive(1, 0, 0, 4'h1, 3'd0, 2'b00, 3'd1); cycle();
    held = ref_result(0, 0, 4'h1, 3'd0, 2'b00, 3'd1);
    drive(1, 0, 1, 4'h2, 3'd1, 2'b01, 3'd2); cycle();
    drive(1, 0, 0, 4'h3, 3'd2, 2'b10, 3'd6);
    check("bp_in_ready_low", {31'd0, in_ready}, 32'd0);
    for (int i = 0; i < 3; i++) begin
      cycle();
      check("bp_accept_blocked", {31'd0, last_acc}, 32'd0);
      check("bp_hold_valid", {31'd0, out_valid}, 32'd1);
      check("bp_hold_res", {24'd0, out_res}, {24'd0, held[7:0]});
    end
    out_ready = 1'b1;
    sent = 2;
    for (int i = 0; i < 20 && sent < 4; i++) begin
      if (sent == 3) drive(1, 0, 1, 4'h4, 3'd4, 2'b01, 3'd2);
      cycle();
      if (last_acc) sent++;
    end
    check("bp_sent", 32'(sent), 32'd4);
    drain();
    check("bp_xfer_count", 32'(n_xfer), 32'd4);
    for (int i = 0; i < 3; i++) begin
      cycle();
      check("bp_no_dup", {31'd0, out_valid}, 32'd0);
    end

    // Overflow counter saturation, then clear against a simultaneous overflow transfer
    sent = 0;
    out_ready = 1'b1;
    drive(1, 0, 1, 4'h0, 3'd2, 2'b01, 3'd6);
    for (int i = 0; i < 400 && sent < 260; i++) begin
      cycle();
      if (last_acc) sent++;
    end
    drain();
    check("ovf_saturated", {24'd0, ovf_cnt}, 32'd255);
    drive(1, 0, 0, 4'h0, 3'd1, 2'b01, 3'd7);
    cycle();
    in_valid = 1'b0;
    cycle();
    check("clr_pending_valid", {31'd0, out_valid}, 32'd1);
    clr_cnt = 1'b1;
    cycle();
    clr_cnt = 1'b0;
    check("clr_wins", {24'd0, ovf_cnt}, 32'd0);

    // Random traffic with random backpressure and occasional clears
    in_valid = 1'b0;
    for (int i = 0; i < 400; i++) begin
      if (last_acc || !in_valid)
        drive($urandom_range(0, 3) != 0, $urandom_range(0, 7) == 0, 1'($urandom),
              4'($urandom), 3'($urandom), 2'($urandom), 3'($urandom));
      out_ready = $urandom_range(0, 3) != 0;
      clr_cnt   = $urandom_range(0, 63) == 0;
      cycle();
    end
    clr_cnt = 1'b0;
    drain();

    // Reset with both stages occupied
    out_ready = 1'b0;
    drive(1, 0, 0, 4'h7, 3'd1, 2'b10, 3'd0); cycle();
    drive(1, 0, 1, 4'h8, 3'd0, 2'b00, 3'd4); cycle();
    check("pre_rst_full", {30'd0, out_valid, in_ready}, 32'd2);
    rst = 1'b1;
    in_valid = 1'b0;
    cycle();
    rst = 1'b0;
    check("mid_rst_valid", {31'd0, out_valid}, 32'd0);
    check("mid_rst_in_ready", {31'd0, in_ready}, 32'd1);
    check("mid_rst_cnts", {16'd0, ovf_cnt, unf_cnt}, 32'd0);
    out_ready = 1'b1;
    for (int i = 0; i < 4; i++) begin
      cycle();
      check("post_rst_quiet", {31'd0, out_valid}, 32'd0);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
